pci_arbiter: RTL and testbench

Central PCI bus arbiter that shares the bus between up to four initiators (Master_Slave instances). It samples the per-master REQ lines plus the shared Frame and IRDY, and drives one GNT line per master. Grants are round-robin, the bus is parked on a default master when nobody requests, and grants that are never used are revoked by a timeout. It sits beside the bus wiring, clocked by the shared CLK.

---
 rtl/pci_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_pci_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pci_arbiter.sv
// pci_arbiter
// Central PCI bus arbiter for up to four initiators. Grants are issued
// round-robin starting after the last master that actually owned the bus.
// The bus parks on PARK_ID when nobody requests. A grant that is never
// used (no FRAME) is revoked after TIMEOUT cycles.
//
// Ports
//   CLK         bus clock, all state changes on the rising edge
//   RST         synchronous active-high reset
//   REQ         per-master request lines, active-low
//   Frame       shared PCI FRAME, active-low
//   IRDY        shared PCI IRDY, active-low
//   GNT         per-master grant lines, active-low, at most one low
//   owner       index of the granted master, held during GAP
//   bus_idle    registered (Frame && IRDY) from the previous edge
//   arb_timeout one-cycle pulse when an unused grant is revoked
module pci_arbiter #(
    parameter int N_MASTERS = 4,
    parameter int PARK_ID   = 0,
    parameter int TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_MASTERS-1:0] REQ,
    input  logic                 Frame,
    input  logic                 IRDY,
    output logic [N_MASTERS-1:0] GNT,
    output logic [1:0]           owner,
    output logic                 bus_idle,
    output logic                 arb_timeout
);

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam logic [1:0] PARK_IDX = 2'(PARK_ID);
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [1:0]             cur_q, cur_d;
    logic [1:0]             last_q, last_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [N_MASTERS-1:0]   gnt_q, gnt_d;
    logic [1:0]             owner_q, owner_d;
    logic                   idle_q;
    logic                   tmo_q, tmo_d;

    logic [3:0]             req_ext;
    logic [3:0]             req_others;
    logic [3:0]             gnt_ext;
    logic                   others_req;
    logic                   win_vld;
    logic [1:0]             win_idx;
    logic [1:0]             cand;

    // Widen REQ to four bits; lines beyond N_MASTERS read as not requesting.
    always_comb begin
        req_ext                 = 4'b1111;
        req_ext[N_MASTERS-1:0]  = REQ;
    end

    // Detect a request from any master other than the current one.
    always_comb begin
        req_others          = req_ext;
        req_others[cur_q]   = 1'b1;
        others_req          = (req_others != 4'b1111);
    end

    // Round-robin winner: first low REQ scanning from last+1, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = 2'((int'(last_q) + k) % N_MASTERS);
            if (!win_vld && !req_ext[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end else begin
                win_vld = win_vld;
            end
        end
    end

    // Next-state logic; the registered outputs are derived from the next state.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_GAP: begin
                cnt_d = 8'd0;
                if (win_vld) begin
                    state_d = ST_GRANT;
                    cur_d   = win_idx;
                end else begin
                    state_d = ST_PARK;
                    cur_d   = PARK_IDX;
                end
            end
            ST_PARK: begin
                cur_d = PARK_IDX;
                if (!Frame) begin
                    state_d = ST_BUSY;
                    last_d  = PARK_IDX;
                end else if (win_vld && (win_idx == PARK_IDX)) begin
                    // Parked master asks for the bus: keep GNT, no gap needed.
                    state_d = ST_GRANT;
                    cnt_d   = 8'd0;
                end else if (win_vld) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_PARK;
                end
            end
            ST_GRANT: begin
                if (!Frame) begin
                    state_d = ST_BUSY;
                    last_d  = cur_q;
                    cnt_d   = 8'd0;
                end else if (req_ext[cur_q]) begin
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    // Unused grant: revoke and demote this master in the rotation.
                    state_d = ST_GAP;
                    tmo_d   = 1'b1;
                    last_d  = cur_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_BUSY: begin
                if (others_req) begin
                    // GNT drops while FRAME may still be low; the owner
                    // completes its transaction and the next master waits for idle.
                    state_d = ST_GAP;
                end else if (idle_q) begin
                    if (!req_ext[cur_q]) begin
                        state_d = ST_GRANT;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_GAP;
                cur_d   = PARK_IDX;
            end
        endcase
    end

    // Grant vector and owner follow the next state so they are registered.
    always_comb begin
        gnt_ext = 4'b1111;
        if (state_d != ST_GAP) begin
            gnt_ext[cur_d] = 1'b0;
            owner_d        = cur_d;
        end else begin
            owner_d        = owner_q;
        end
        gnt_d = gnt_ext[N_MASTERS-1:0];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_GAP;
            cur_q   <= PARK_IDX;
            last_q  <= PARK_IDX;
            cnt_q   <= 8'd0;
            gnt_q   <= {N_MASTERS{1'b1}};
            owner_q <= PARK_IDX;
            idle_q  <= 1'b1;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            idle_q  <= Frame & IRDY;
            tmo_q   <= tmo_d;
        end
    end

    assign GNT         = gnt_q;
    assign owner       = owner_q;
    assign bus_idle    = idle_q;
    assign arb_timeout = tmo_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: each cycle pushes the expected
// outputs into a scoreboard queue when stimulus is applied, then pops and
// compares after the clock edge.
module tb_pci_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic       Frame;
    logic       IRDY;
    logic [3:0] GNT;
    logic [1:0] owner;
    logic       bus_idle;
    logic       arb_timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] own;
        logic       tmo;
        logic       idle;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;

    pci_arbiter #(
        .N_MASTERS (4),
        .PARK_ID   (0),
        .TIMEOUT   (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .REQ         (REQ),
        .Frame       (Frame),
        .IRDY        (IRDY),
        .GNT         (GNT),
        .owner       (owner),
        .bus_idle    (bus_idle),
        .arb_timeout (arb_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of stimulus, record the expectation, compare after the edge.
    task automatic cyc(input logic rst_v, input logic [3:0] req_v, input logic f_v,
                       input logic i_v, input logic [3:0] eg, input logic [1:0] eo,
                       input logic et, input string tag);
        exp_t e;
        @(negedge CLK);
        RST   = rst_v;
        REQ   = req_v;
        Frame = f_v;
        IRDY  = i_v;
        e.gnt  = eg;
        e.own  = eo;
        e.tmo  = et;
        e.idle = rst_v ? 1'b1 : (f_v & i_v);
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        e = exp_q.pop_front();
        check_val({tag, ".gnt"},  32'(GNT),         32'(e.gnt));
        check_val({tag, ".own"},  32'(owner),       32'(e.own));
        check_val({tag, ".tmo"},  32'(arb_timeout), 32'(e.tmo));
        check_val({tag, ".idle"}, 32'(bus_idle),    32'(e.idle));
    endtask

    initial begin
        int ord [5];
        n_checks = 0;
        n_fail   = 0;
        RST   = 1'b1;
        REQ   = 4'b1111;
        Frame = 1'b1;
        IRDY  = 1'b1;
        ord   = '{1, 2, 3, 0, 1};

        // Reset, one GAP cycle, then park on 0 and stay there.
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "reset");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "park");
        repeat (20) cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "park_hold");

        // Master 1 request from parked bus, burst, back-to-back regrant, release.
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "t2_gap");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, "t2_grant");
        repeat (4) cyc(1'b0, 4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0, "t2_busy");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, "t2_idle_wait");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, "t2_release_gap");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "t2_repark");

        // Round robin with all four requesting; start from a fresh reset.
        cyc(1'b1, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "t3_reset");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "t3_park");
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "t3_gap0");
        cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, "t3_grant1");
        for (int n = 0; n < 4; n++) begin
            cyc(1'b0, 4'b0000, 1'b0, 1'b1, 4'(~(4'b0001 << ord[n])), 2'(ord[n]), 1'b0, "rr_busy");
            cyc(1'b0, 4'b0000, 1'b0, 1'b1, 4'b1111, 2'(ord[n]), 1'b0, "rr_gap");
            cyc(1'b0, 4'b0000, 1'b1, 1'b1, 4'(~(4'b0001 << ord[n+1])), 2'(ord[n+1]), 1'b0, "rr_grant");
        end
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0, "t3_gap_end");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "t3_repark");

        // Unused grant to master 2 times out after 16 cycles; 3 is next.
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "t4_gap");
        cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, "t4_grant");
        repeat (15) cyc(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1011, 2'd2, 1'b0, "t4_hold");
        cyc(1'b0, 4'b0011, 1'b1, 1'b1, 4'b1111, 2'd2, 1'b1, "t4_timeout");
        cyc(1'b0, 4'b0011, 1'b1, 1'b1, 4'b0111, 2'd3, 1'b0, "t4_next3");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1111, 2'd3, 1'b0, "t4_gap_end");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "t4_repark");

        // Master 1 busy, master 3 requests: handover while FRAME still low.
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1111, 2'd0, 1'b0, "t5_gap");
        cyc(1'b0, 4'b1101, 1'b1, 1'b1, 4'b1101, 2'd1, 1'b0, "t5_grant1");
        cyc(1'b0, 4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0, "t5_busy1");
        cyc(1'b0, 4'b1101, 1'b0, 1'b1, 4'b1101, 2'd1, 1'b0, "t5_busy1b");
        cyc(1'b0, 4'b0111, 1'b0, 1'b1, 4'b1111, 2'd1, 1'b0, "t5_revoke1");
        cyc(1'b0, 4'b0111, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b0, "t5_grant3");
        repeat (3) cyc(1'b0, 4'b0111, 1'b0, 1'b1, 4'b0111, 2'd3, 1'b0, "t5_hold3");

        // Reset in the middle of a transaction, then park again.
        cyc(1'b1, 4'b0111, 1'b0, 1'b1, 4'b1111, 2'd0, 1'b0, "t6_reset");
        cyc(1'b0, 4'b1111, 1'b1, 1'b1, 4'b1110, 2'd0, 1'b0, "t6_park");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
